// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the digit counter for WIDTH/DIGIT steps (at least 1 bit).
  function automatic int unsigned cnt_width(input int unsigned width, input int unsigned digit);
    int unsigned n;
    n = width / digit;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result valid-ready bundle for serial_subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero, ovf
  );
endinterface

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit ripple-borrow subtract slice: {bo,d} = x - y - bi.
module sub_digit #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  logic [DIGIT:0] br;

  always_comb begin
    br    = '0;
    d     = '0;
    br[0] = bi;
    for (int i = 0; i < int'(DIGIT); i++) begin
      d[i]    = x[i] ^ y[i] ^ br[i];
      br[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
    end
  end

  assign bo = br[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per clock, LSB first.
// Optional zero/ovf flags are built only when SERIAL_SUB_FLAGS_EN is defined.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = cnt_width(WIDTH, DIGIT);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_q;
  logic             brw;
  logic             bout_q;
  logic             out_valid_q;

  logic [DIGIT-1:0] d_c;
  logic             bo_c;
  logic [WIDTH-1:0] diff_next_c;
  logic             last_c;

  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .x  (a_sh[DIGIT-1:0]),
    .y  (b_sh[DIGIT-1:0]),
    .bi (brw),
    .d  (d_c),
    .bo (bo_c)
  );

  // New digit enters at the MSB so the LSB digit ends up at bit 0 after N steps.
  assign diff_next_c = {d_c, diff_q[WIDTH-1:DIGIT]};
  assign last_c      = (count == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      diff_q      <= '0;
      brw         <= 1'b0;
      bout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            brw   <= bus.bin;
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          brw    <= bo_c;
          diff_q <= diff_next_c;
          count  <= count + CW'(1);
          if (last_c) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            bout_q      <= bo_c;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_SUB_FLAGS_EN
  logic a_msb;
  logic b_msb;
  logic zero_q;
  logic ovf_q;

  // Operand MSBs are captured at accept because the shift registers consume them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
    end else if (state == RUN && last_c) begin
      zero_q <= (diff_next_c == '0);
      ovf_q  <= (a_msb != b_msb) && (d_c[DIGIT-1] != a_msb);
    end
  end

  assign bus.zero = zero_q;
  assign bus.ovf  = ovf_q;
`else
  assign bus.zero = 1'b0;
  assign bus.ovf  = 1'b0;
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor (WIDTH=32, DIGIT=4).
module tb_serial_subtractor;

`ifdef SERIAL_SUB_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

  serial_subtractor_if #(.WIDTH(32)) bus ();

  serial_subtractor #(.WIDTH(32), .DIGIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one op, wait for the result, hold it for 'stall' cycles, then take it.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                       input int stall, output logic [31:0] d, output logic bo,
                       output logic z, output logic o, output int lat);
    @(negedge clk);
    check("in_ready_before_op", 64'(bus.in_ready), 64'(1));
    bus.a = a; bus.b = b; bus.bin = bin; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.bin = 1'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 50) check("latency_bound", 64'(bus.out_valid), 64'(1));
    d = bus.diff; bo = bus.bout; z = bus.zero; o = bus.ovf;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("out_valid_drops", 64'(bus.out_valid), 64'(0));
  endtask

  initial begin
    logic [31:0] d, ra, rb, held;
    logic        bo, z, o, rbin;
    logic [32:0] gold;
    int          lat;

    n_cmp = 0; n_mis = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(bus.in_ready),  64'(1));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_diff",      64'(bus.diff),      64'(0));
    check("rst_bout",      64'(bus.bout),      64'(0));
    check("rst_zero",      64'(bus.zero),      64'(0));
    check("rst_ovf",       64'(bus.ovf),       64'(0));
    @(negedge clk); rst_n = 1'b1;

    // 1: basic, with latency
    do_op(32'h0000000A, 32'h00000003, 1'b0, 0, d, bo, z, o, lat);
    check("t1_diff", 64'(d), 64'h00000007);
    check("t1_bout", 64'(bo), 64'(0));
    check("t1_lat",  64'(lat), 64'(8));

    // 2: borrow out
    do_op(32'h00000000, 32'h00000001, 1'b0, 1, d, bo, z, o, lat);
    check("t2a_diff", 64'(d), 64'hFFFFFFFF);
    check("t2a_bout", 64'(bo), 64'(1));
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, d, bo, z, o, lat);
    check("t2b_diff", 64'(d), 64'hFFFFFFFF);
    check("t2b_bout", 64'(bo), 64'(1));

    // 3: flags (zero/ovf expected low when the flag build is off)
    do_op(32'h80000000, 32'h00000001, 1'b0, 0, d, bo, z, o, lat);
    check("t3a_diff", 64'(d), 64'h7FFFFFFF);
    check("t3a_ovf",  64'(o), 64'(FL));
    check("t3a_zero", 64'(z), 64'(0));
    do_op(32'h00000005, 32'h00000004, 1'b1, 0, d, bo, z, o, lat);
    check("t3b_diff", 64'(d), 64'h00000000);
    check("t3b_zero", 64'(z), 64'(FL));
    check("t3b_ovf",  64'(o), 64'(0));
    check("t3b_bout", 64'(bo), 64'(0));

    // 4: long stall in DONE, in_valid ignored
    @(negedge clk);
    bus.a = 32'h00000100; bus.b = 32'h00000001; bus.bin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    held = bus.diff;
    check("t4_diff", 64'(held), 64'h000000FF);
    bus.a = 32'hDEADBEEF; bus.b = 32'h11111111; bus.bin = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t4_hold_valid", 64'(bus.out_valid), 64'(1));
      check("t4_hold_diff",  64'(bus.diff),      64'(held));
      check("t4_in_ready",   64'(bus.in_ready),  64'(0));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("t4_released", 64'(bus.out_valid), 64'(0));
    do_op(32'h00000050, 32'h00000020, 1'b0, 0, d, bo, z, o, lat);
    check("t4_next_diff", 64'(d), 64'h00000030);

    // 5: reset mid-run
    @(negedge clk);
    bus.a = 32'hFFFF0000; bus.b = 32'h0000FFFF; bus.bin = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_out_valid", 64'(bus.out_valid), 64'(0));
    check("t5_in_ready",  64'(bus.in_ready),  64'(1));
    check("t5_diff",      64'(bus.diff),      64'(0));
    @(negedge clk); rst_n = 1'b1;
    do_op(32'h12345678, 32'h00000678, 1'b0, 0, d, bo, z, o, lat);
    check("t5_diff_after", 64'(d), 64'h12345000);
    check("t5_bout_after", 64'(bo), 64'(0));

    // 6: random operands with random stalls against a golden subtract
    for (int k = 0; k < 100; k++) begin
      ra = $urandom; rb = $urandom; rbin = 1'($urandom);
      if (k == 0) begin ra = 32'h7FFFFFFF; rb = 32'hFFFFFFFF; rbin = 1'b0; end
      gold = {1'b0, ra} - {1'b0, rb} - 33'(rbin);
      do_op(ra, rb, rbin, int'($urandom_range(0, 3)), d, bo, z, o, lat);
      check("rnd_diff", 64'(d),  64'(gold[31:0]));
      check("rnd_bout", 64'(bo), 64'(gold[32]));
      check("rnd_zero", 64'(z),  64'(FL && (gold[31:0] == 32'd0)));
      check("rnd_ovf",  64'(o),  64'(FL && (ra[31] != rb[31]) && (gold[31] != ra[31])));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
